dpe_axis_fifo: RTL and testbench
================================

DPE_AXIS_FIFO -- requirements
Module: dpe_axis_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 128, tdata width in bits; legal values are multiples of 8, from 8 to 512.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; legal values are powers of two, 2..1024.
REQ-003 SHALL have parameter USER_W, default 8, tuser width: {bypass_all, bypass_stage, src[2:0], dst[2:0]}.
REQ-004 SHALL have parameter ID_W, default 8, tid width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; all other ports are synchronous to clk.
REQ-006 SHALL have these ports, in this order:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  FIFO can accept a beat.
- s_axis_tdata  in  DATA_W  payload.
- s_axis_tkeep  in  DATA_W/8  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tuser  in  USER_W  sideband.
- s_axis_tid  in  ID_W  flow id.
- m_axis_*  out (m_axis_tready in)  same widths as s_axis_*  output stream.
- fill_level  out  $clog2(DEPTH)+1  entries currently stored.
- pkt_count  out  $clog2(DEPTH)+1  complete packets (tlast beats) stored.

Function
REQ-007 SHALL store tdata, tkeep, tlast, tuser and tid as one entry per accepted beat (s_axis_tvalid & s_axis_tready).
REQ-008 SHALL pop one entry per m_axis_tvalid & m_axis_tready beat, strictly in FIFO order.
REQ-009 SHALL drive s_axis_tready = (fill_level < DEPTH) from registered state only, with no combinational path from m_axis_tready.
REQ-010 SHALL assert m_axis_tvalid no earlier than the cycle after a write into an empty FIFO (1-cycle fall-through latency).
REQ-011 SHALL hold m_axis_* payload stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-012 SHALL never deassert m_axis_tvalid before the handshake completes.
REQ-013 SHALL, on a simultaneous push and pop, leave fill_level unchanged and sustain 1 beat/cycle throughput.
REQ-014 SHALL ignore a push when full; no overwrite occurs, because s_axis_tready=0 when full.
REQ-015 SHALL never produce a pop when empty, because m_axis_tvalid=0 when empty.
REQ-016 SHALL wrap its read and write pointers modulo DEPTH; full vs empty SHALL be distinguished via fill_level.
REQ-017 SHALL update pkt_count as follows: +1 on a push with tlast, -1 on a pop with tlast, unchanged when both occur in the same cycle.
REQ-018 SHALL update fill_level and pkt_count in the cycle after the handshake.

Reset
REQ-019 SHALL, while rst=1, asynchronously force: s_axis_tready=0, m_axis_tvalid=0, fill_level=0, pkt_count=0, pointers=0, m_axis payload=0.
REQ-020 SHALL drive s_axis_tready=1 in the first cycle after rst deasserts; storage contents are not reset.
REQ-021 SHALL discard all stored beats, including partial packets, on reset mid-operation; no beat is emitted afterwards.

Configuration
REQ-022 SHALL use the macro DPE_FIFO_PKT_MODE_EN to select packet mode.
REQ-023 SHALL, with DPE_FIFO_PKT_MODE_EN defined, operate store-and-forward:
- m_axis_tvalid asserts only while pkt_count>0 or a packet is already in flight.
- Once the first beat of a packet is popped, output continues through tlast without waiting.
REQ-024 SHALL, with DPE_FIFO_PKT_MODE_EN defined and the FIFO full with pkt_count=0 (packet longer than DEPTH), release beats cut-through to avoid deadlock.
REQ-025 SHALL, without DPE_FIFO_PKT_MODE_EN, operate cut-through per REQ-010; pkt_count remains functional.

Structure
REQ-026 SHALL place the default widths and the tuser field layout (typedef dpe_tuser_t, field offsets) in the shared package dpe_pkg.
REQ-027 SHALL instantiate storage as sub-module dpe_fifo_ram: simple dual-port, synchronous write, registered read, width = DATA_W + DATA_W/8 + 1 + USER_W + ID_W.
REQ-028 SHALL keep all control (pointers, counters, output staging, packet gating) in dpe_axis_fifo.

Verification
REQ-029 Single beat: push tdata=0x0123..EF, tlast=1 into empty FIFO -> m_axis_tvalid=1 exactly 1 cycle later with identical tkeep/tuser/tid; fill_level 1 -> 0 after pop.
REQ-030 Fill: DEPTH=16, m_axis_tready=0, push 20 beats -> s_axis_tready=0 after 16 accepted; fill_level=16; beats 17..20 held off, not lost.
REQ-031 Streaming: tvalid=tready=1 on both sides for 100 cycles -> 1 beat/cycle out, order preserved, fill_level constant.
REQ-032 Backpressure: random m_axis_tready 50% -> payload stable across stalls; output sequence identical to input.
REQ-033 Packet mode on: push 4-beat packet with 2-cycle gaps -> m_axis_tvalid stays 0 until tlast is stored; 20-beat packet with DEPTH=16 -> completes without deadlock.
REQ-034 Reset mid-packet: rst after 3 of 5 beats -> fill_level=0, pkt_count=0, m_axis_tvalid=0; a following new packet passes intact.

Source files
------------

// File: rtl/dpe_pkg.sv
// Shared definitions for the DPE AXI-Stream FIFO: default widths, the
// tuser sideband layout and the stored-entry width helper.
package dpe_pkg;

   // Default stream geometry
   localparam int DPE_DATA_W = 128;
   localparam int DPE_DEPTH  = 16;
   localparam int DPE_USER_W = 8;
   localparam int DPE_ID_W   = 8;

   // tuser layout: {bypass_all, bypass_stage, src[2:0], dst[2:0]}
   localparam int TUSER_DST_LSB          = 0;
   localparam int TUSER_DST_W            = 3;
   localparam int TUSER_SRC_LSB          = 3;
   localparam int TUSER_SRC_W            = 3;
   localparam int TUSER_BYPASS_STAGE_BIT = 6;
   localparam int TUSER_BYPASS_ALL_BIT   = 7;

   typedef struct packed {
      logic       bypass_all;
      logic       bypass_stage;
      logic [2:0] src;
      logic [2:0] dst;
   } dpe_tuser_t;

   // Width of one stored beat: tdata + tkeep + tlast + tuser + tid
   function automatic int dpe_entry_w(input int data_w, input int user_w, input int id_w);
      return data_w + data_w / 8 + 1 + user_w + id_w;
   endfunction

endpackage

// File: rtl/dpe_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: synchronous write,
// registered read. Contents are deliberately not reset so the array maps
// onto block RAM.
module dpe_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port (old data on a same-address collision)
   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/dpe_axis_fifo.sv
// AXI-Stream FIFO with sideband (tkeep/tlast/tuser/tid), fill and packet
// counters. Default build is cut-through with one cycle of fall-through
// latency. Define DPE_FIFO_PKT_MODE_EN for store-and-forward packet mode,
// which falls back to cut-through when full with no complete packet.
//
// The RAM read address runs one step ahead (next read pointer), so its
// registered output always holds the head entry. A write landing on that
// address in the same cycle is captured into a bypass register instead.
module dpe_axis_fifo
   import dpe_pkg::*;
#(
   parameter int DATA_W = DPE_DATA_W,
   parameter int DEPTH  = DPE_DEPTH,
   parameter int USER_W = DPE_USER_W,
   parameter int ID_W   = DPE_ID_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [DATA_W-1:0]        s_axis_tdata,
   input  logic [DATA_W/8-1:0]      s_axis_tkeep,
   input  logic                     s_axis_tlast,
   input  logic [USER_W-1:0]        s_axis_tuser,
   input  logic [ID_W-1:0]          s_axis_tid,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic [DATA_W/8-1:0]      m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic [USER_W-1:0]        m_axis_tuser,
   output logic [ID_W-1:0]          m_axis_tid,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [$clog2(DEPTH):0]   pkt_count
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = $clog2(DEPTH) + 1;
   localparam int KW       = DATA_W / 8;
   localparam int EW       = dpe_entry_w(DATA_W, USER_W, ID_W);
   localparam int KEEP_LSB = DATA_W;
   localparam int LAST_BIT = DATA_W + KW;
   localparam int USER_LSB = LAST_BIT + 1;
   localparam int ID_LSB   = USER_LSB + USER_W;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] rd_addr_next;
   logic [CW-1:0] fill_reg;
   logic [CW-1:0] fill_next;
   logic [CW-1:0] pkt_reg;
   logic [CW-1:0] pkt_next;
   logic          in_ready_reg;
   logic          out_valid_reg;
   logic          valid_next;
   logic          bypass_sel_reg;
   logic [EW-1:0] bypass_data_reg;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] ram_q;
   logic [EW-1:0] head_entry;
   logic [EW-1:0] out_entry;
   logic          push;
   logic          pop;
   logic          head_last;

   assign push         = s_axis_tvalid & in_ready_reg;
   assign pop          = out_valid_reg & m_axis_tready;
   assign wr_entry     = {s_axis_tid, s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
   assign head_entry   = bypass_sel_reg ? bypass_data_reg : ram_q;
   assign head_last    = head_entry[LAST_BIT];
   assign rd_addr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

   dpe_fifo_ram #(
      .WIDTH (EW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr_reg),
      .wr_data (wr_entry),
      .rd_addr (rd_addr_next),
      .rd_data (ram_q)
   );

   // Next fill level and complete-packet count from this cycle's handshakes
   always_comb begin
      fill_next = fill_reg;
      pkt_next  = pkt_reg;
      if (push && !pop) begin
         fill_next = fill_reg + CW'(1);
      end else if (!push && pop) begin
         fill_next = fill_reg - CW'(1);
      end
      if ((push && s_axis_tlast) && !(pop && head_last)) begin
         pkt_next = pkt_reg + CW'(1);
      end else if (!(push && s_axis_tlast) && (pop && head_last)) begin
         pkt_next = pkt_reg - CW'(1);
      end
   end

`ifdef DPE_FIFO_PKT_MODE_EN
   logic in_flight_reg;
   logic in_flight_next;

   assign in_flight_next = pop ? ~head_last : in_flight_reg;

   // Remember that a packet has started leaving so it drains through tlast
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight_reg <= 1'b0;
      end else begin
         in_flight_reg <= in_flight_next;
      end
   end

   // Present data only for a complete packet, one already in flight, or a
   // full FIFO holding no tlast (oversized packet released cut-through)
   assign valid_next = (fill_next != '0) &&
                       ((pkt_next != '0) || in_flight_next || (fill_next == FULL_LVL));
`else
   assign valid_next = (fill_next != '0);
`endif

   // Pointers, counters, handshake flags and collision bypass
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         fill_reg        <= '0;
         pkt_reg         <= '0;
         in_ready_reg    <= 1'b0;
         out_valid_reg   <= 1'b0;
         bypass_sel_reg  <= 1'b0;
         bypass_data_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg      <= wr_ptr_reg + AW'(1);
            bypass_data_reg <= wr_entry;
         end
         rd_ptr_reg     <= rd_addr_next;
         fill_reg       <= fill_next;
         pkt_reg        <= pkt_next;
         in_ready_reg   <= (fill_next < FULL_LVL);
         out_valid_reg  <= valid_next;
         bypass_sel_reg <= push && (wr_ptr_reg == rd_addr_next);
      end
   end

   // Payload reads as zero whenever nothing is being offered
   assign out_entry     = out_valid_reg ? head_entry : '0;
   assign m_axis_tvalid = out_valid_reg;
   assign m_axis_tdata  = out_entry[DATA_W-1:0];
   assign m_axis_tkeep  = out_entry[KEEP_LSB +: KW];
   assign m_axis_tlast  = out_entry[LAST_BIT];
   assign m_axis_tuser  = out_entry[USER_LSB +: USER_W];
   assign m_axis_tid    = out_entry[ID_LSB +: ID_W];
   assign s_axis_tready = in_ready_reg;
   assign fill_level    = fill_reg;
   assign pkt_count     = pkt_reg;

endmodule

// File: tb/tb_dpe_axis_fifo.sv
// Directed self-checking bench for dpe_axis_fifo (default geometry).
// Handshakes are evaluated 1 time unit after each rising edge; popped beats
// are compared against a queue of the beats the bench pushed.
module tb_dpe_axis_fifo;

   localparam int DATA_W = 128;
   localparam int DEPTH  = 16;
   localparam int USER_W = 8;
   localparam int ID_W   = 8;
   localparam int CW     = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ID_W-1:0]     id;
      logic [USER_W-1:0]   user;
      logic                last;
      logic [DATA_W/8-1:0] keep;
      logic [DATA_W-1:0]   data;
   } beat_t;

   logic                clk;
   logic                rst;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic [DATA_W-1:0]   s_axis_tdata;
   logic [DATA_W/8-1:0] s_axis_tkeep;
   logic                s_axis_tlast;
   logic [USER_W-1:0]   s_axis_tuser;
   logic [ID_W-1:0]     s_axis_tid;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic [DATA_W-1:0]   m_axis_tdata;
   logic [DATA_W/8-1:0] m_axis_tkeep;
   logic                m_axis_tlast;
   logic [USER_W-1:0]   m_axis_tuser;
   logic [ID_W-1:0]     m_axis_tid;
   logic [CW-1:0]       fill_level;
   logic [CW-1:0]       pkt_count;

   int    n_checks;
   int    n_errors;
   int    pops;
   int    idx;
   bit    acc;
   beat_t cur;
   beat_t held;
   beat_t exp_q[$];

   dpe_axis_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .USER_W (USER_W),
      .ID_W   (ID_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tid    (s_axis_tid),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tid    (m_axis_tid),
      .fill_level    (fill_level),
      .pkt_count     (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk_beat(input int i, input bit last);
      beat_t b;
      b.data = {32'hDA7A0000 + 32'(i), ~32'(i), 32'(i * 3), 32'h12340000 + 32'(i)};
      b.keep = 16'hFFFF >> (i % 4);
      b.last = last;
      b.user = 8'(i * 7);
      b.id   = 8'h40 + 8'(i);
      return b;
   endfunction

   function automatic beat_t out_beat();
      beat_t b;
      b = {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      return b;
   endfunction

   task automatic set_beat(input beat_t b, input logic v);
      cur           = b;
      s_axis_tvalid = v;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tlast  = b.last;
      s_axis_tuser  = b.user;
      s_axis_tid    = b.id;
   endtask

   // One clock: score this cycle's handshakes, then advance past the edge
   task automatic cycle();
      beat_t got;
      got = out_beat();
      if (m_axis_tvalid && m_axis_tready) begin
         pops++;
         if (exp_q.size() == 0) begin
            check_eq("pop_when_none_expected", 192'(exp_q.size()), 192'(1));
         end else begin
            check_eq("pop_data", 192'(got), 192'(exp_q.pop_front()));
         end
      end
      if (s_axis_tvalid && s_axis_tready) begin
         exp_q.push_back(cur);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
         cycle();
      end
      check_eq(tag, 192'(exp_q.size()), 192'(0));
      check_eq({tag, "_fill"}, 192'(fill_level), 192'(0));
      check_eq({tag, "_pkt"}, 192'(pkt_count), 192'(0));
   endtask

   initial begin
      beat_t b0;
      n_checks = 0;
      n_errors = 0;
      pops     = 0;
      rst      = 1'b1;
      m_axis_tready = 1'b0;
      set_beat(mk_beat(0, 1'b0), 1'b0);

      // ---- reset state ----
      #1;
      check_eq("rst_tready", 192'(s_axis_tready), 192'(0));
      check_eq("rst_tvalid", 192'(m_axis_tvalid), 192'(0));
      check_eq("rst_fill", 192'(fill_level), 192'(0));
      check_eq("rst_pkt", 192'(pkt_count), 192'(0));
      check_eq("rst_tdata", 192'(m_axis_tdata), 192'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("tready_after_rst", 192'(s_axis_tready), 192'(1));

      // ---- single beat, 1-cycle fall-through ----
      b0.data = 128'h0123456789ABCDEF0123456789ABCDEF;
      b0.keep = 16'hFFFF;
      b0.last = 1'b1;
      b0.user = 8'hA5;
      b0.id   = 8'h3C;
      set_beat(b0, 1'b1);
      check_eq("single_pre_tvalid", 192'(m_axis_tvalid), 192'(0));
      cycle();
      s_axis_tvalid = 1'b0;
      check_eq("single_tvalid", 192'(m_axis_tvalid), 192'(1));
      check_eq("single_payload", 192'(out_beat()), 192'(b0));
      check_eq("single_fill1", 192'(fill_level), 192'(1));
      check_eq("single_pkt1", 192'(pkt_count), 192'(1));
      m_axis_tready = 1'b1;
      cycle();
      check_eq("single_fill0", 192'(fill_level), 192'(0));
      check_eq("single_pkt0", 192'(pkt_count), 192'(0));
      check_eq("single_tvalid0", 192'(m_axis_tvalid), 192'(0));

      // ---- fill: 20 offered with sink stalled, 16 accepted ----
      m_axis_tready = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         set_beat(mk_beat(idx, (idx % 4) == 3), 1'b1);
         acc = s_axis_tready;
         cycle();
         if (acc) idx++;
      end
      check_eq("fill_accepted", 192'(idx), 192'(16));
      check_eq("fill_level16", 192'(fill_level), 192'(16));
      check_eq("fill_tready0", 192'(s_axis_tready), 192'(0));
      check_eq("fill_pkt4", 192'(pkt_count), 192'(4));
      check_eq("fill_head", 192'(out_beat()), 192'(mk_beat(0, 1'b0)));
      m_axis_tready = 1'b1;
      for (int n = 0; n < 100 && !(idx == 20 && exp_q.size() == 0); n++) begin
         if (idx < 20) set_beat(mk_beat(idx, (idx % 4) == 3), 1'b1);
         else s_axis_tvalid = 1'b0;
         acc = s_axis_tvalid && s_axis_tready;
         cycle();
         if (acc) idx++;
      end
      check_eq("fill_all_sent", 192'(idx), 192'(20));
      drain("fill_drain");

      // ---- streaming: both sides always ready ----
      pops = 0;
      m_axis_tready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         set_beat(mk_beat(100 + c, (c % 4) == 3), 1'b1);
         cycle();
`ifndef DPE_FIFO_PKT_MODE_EN
         check_eq("stream_fill", 192'(fill_level), 192'(1));
`endif
      end
`ifndef DPE_FIFO_PKT_MODE_EN
      check_eq("stream_pops", 192'(pops), 192'(99));
`endif
      drain("stream_drain");

      // ---- random backpressure, payload held across stalls ----
      idx = 0;
      for (int n = 0; n < 1000 && idx < 60; n++) begin
         set_beat(mk_beat(300 + idx, (idx % 4) == 3), ($urandom_range(3) != 0));
         m_axis_tready = ($urandom_range(1) == 1);
         acc  = s_axis_tvalid && s_axis_tready;
         held = out_beat();
         if (m_axis_tvalid && !m_axis_tready) begin
            cycle();
            check_eq("bp_valid_held", 192'(m_axis_tvalid), 192'(1));
            check_eq("bp_payload_held", 192'(out_beat()), 192'(held));
         end else begin
            cycle();
         end
         if (acc) idx++;
      end
      check_eq("bp_all_sent", 192'(idx), 192'(60));
      drain("bp_drain");

      // ---- reset in the middle of a packet ----
      m_axis_tready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_beat(mk_beat(500 + k, 1'b0), 1'b1);
         cycle();
      end
      check_eq("mid_fill3", 192'(fill_level), 192'(3));
      #2;
      rst = 1'b1;
      #1;
      check_eq("mid_rst_fill", 192'(fill_level), 192'(0));
      check_eq("mid_rst_pkt", 192'(pkt_count), 192'(0));
      check_eq("mid_rst_tvalid", 192'(m_axis_tvalid), 192'(0));
      check_eq("mid_rst_tready", 192'(s_axis_tready), 192'(0));
      exp_q.delete();
      s_axis_tvalid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("mid_tready_back", 192'(s_axis_tready), 192'(1));
      check_eq("mid_tvalid_idle", 192'(m_axis_tvalid), 192'(0));
      pops = 0;
      m_axis_tready = 1'b1;
      set_beat(mk_beat(600, 1'b0), 1'b1);
      cycle();
      set_beat(mk_beat(601, 1'b1), 1'b1);
      cycle();
      drain("mid_drain");
      check_eq("mid_new_pkt_pops", 192'(pops), 192'(2));

`ifdef DPE_FIFO_PKT_MODE_EN
      // ---- packet mode: hold until tlast stored ----
      m_axis_tready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         set_beat(mk_beat(700 + b, b == 3), 1'b1);
         cycle();
         s_axis_tvalid = 1'b0;
         if (b < 3) begin
            check_eq("pkt_hold", 192'(m_axis_tvalid), 192'(0));
            cycle();
            check_eq("pkt_hold_gap", 192'(m_axis_tvalid), 192'(0));
            cycle();
            check_eq("pkt_hold_gap", 192'(m_axis_tvalid), 192'(0));
         end else begin
            check_eq("pkt_release", 192'(m_axis_tvalid), 192'(1));
         end
      end
      drain("pkt_drain");

      // ---- packet mode: oversized packet must not deadlock ----
      idx = 0;
      for (int n = 0; n < 200 && idx < 20; n++) begin
         set_beat(mk_beat(800 + idx, idx == 19), 1'b1);
         acc = s_axis_tready;
         cycle();
         if (acc) idx++;
      end
      check_eq("pkt_long_sent", 192'(idx), 192'(20));
      drain("pkt_long_drain");
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
